// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divide/remainder unit (div, divu, rem, remu, RV64 W-variants)
// Ports: clk, reset (sync, active-high); valid/op/word/a/b request, flush abort;
//        ready (IDLE), busy (not IDLE), done (one-cycle result pulse), result.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [1:0]  op,
  input  logic        word,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [6:0] cnt;
  logic [63:0] quo, rem, dv;
  logic wl, isrem, negq, negr;
  logic sgn, sa, sb, dz, ovf, accept, ge;
  logic [63:0] ae, be, am, bm, spec, spec_x, nquo, nrem, qv, rv, fin, fin_x;
  logic [64:0] r_sh, diff;
  always_comb begin
    sgn = ~op[0];
    ae = word ? {{32{sgn & a[31]}}, a[31:0]} : a;
    be = word ? {{32{sgn & b[31]}}, b[31:0]} : b;
    sa = sgn & ae[63];
    sb = sgn & be[63];
    am = sa ? -ae : ae;
    bm = sb ? -be : be;
    dz = be == 64'd0;
    // most-negative / -1 in the effective operand width
    ovf = sgn & (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                      : (a == 64'h8000_0000_0000_0000 && &b));
    spec = dz ? (op[1] ? ae : '1) : (op[1] ? 64'd0 : ae);
    spec_x = word ? {{32{spec[31]}}, spec[31:0]} : spec;
    accept = state == IDLE && valid && !flush;
    r_sh = {rem, quo[63]};
    diff = r_sh - {1'b0, dv};
    ge = ~diff[64];
    nrem = ge ? diff[63:0] : r_sh[63:0];
    nquo = {quo[62:0], ge};
    // in word mode the upper halves are discarded by the final sign-extension
    qv = negq ? -nquo : nquo;
    rv = negr ? -nrem : nrem;
    fin = isrem ? rv : qv;
    fin_x = wl ? {{32{fin[31]}}, fin[31:0]} : fin;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? ((dz || ovf) ? DONE : BUSY) : IDLE;
      BUSY: state_n = flush ? IDLE : (cnt == 7'd0 ? DONE : BUSY);
      default: state_n = IDLE;
    endcase
    ready = state == IDLE;
    busy = state != IDLE;
    done = state == DONE && !flush;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 7'd0;
      result <= 64'd0;
      quo <= 64'd0;
      rem <= 64'd0;
      dv <= 64'd0;
      wl <= 1'b0;
      isrem <= 1'b0;
      negq <= 1'b0;
      negr <= 1'b0;
    end else if (accept) begin
      wl <= word;
      isrem <= op[1];
      negq <= sa ^ sb;
      negr <= sa;
      dv <= bm;
      // word dividends start in the top half so 32 shifts consume them
      quo <= word ? {am[31:0], 32'd0} : am;
      rem <= 64'd0;
      cnt <= word ? 7'd31 : 7'd63;
      if (dz || ovf) result <= spec_x;
    end else if (state == BUSY) begin
      quo <= nquo;
      rem <= nrem;
      cnt <= cnt - 7'(cnt != 7'd0);
      if (cnt == 7'd0) result <= fin_x;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
  logic clk = 0, reset, valid, word, flush;
  logic [1:0] op;
  logic [63:0] a, b;
  logic ready, busy, done;
  logic [63:0] result;
  int pass = 0, total = 0;
  div_unit dut (.clk(clk), .reset(reset), .valid(valid), .op(op), .word(word), .a(a), .b(b),
                .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [1:0] o, input logic w, input logic [63:0] x, input logic [63:0] y,
                     input int lat, input logic [63:0] exp, input string nm);
    int k;
    op = o; word = w; a = x; b = y; valid = 1;
    total++;
    if (ready !== 1'b1) $display("FAIL %s ready before accept: got %b want 1", nm, ready); else pass++;
    step;
    valid = 0; op = ~o; word = ~w; a = ~x; b = ~y;
    total++;
    if (busy !== 1'b1 || ready !== 1'b0) $display("FAIL %s busy after accept: busy=%b ready=%b want 1/0", nm, busy, ready); else pass++;
    k = 1;
    while (done !== 1'b1 && k < 200) begin
      step;
      k++;
    end
    total++;
    if (done !== 1'b1 || k != lat) $display("FAIL %s latency: got %0d done=%b want %0d", nm, k, done, lat); else pass++;
    total++;
    if (result !== exp) $display("FAIL %s result: got %h want %h", nm, result, exp); else pass++;
    step;
    total++;
    if (done !== 1'b0 || ready !== 1'b1 || result !== exp)
      $display("FAIL %s after done: done=%b ready=%b result=%h want 0/1/%h", nm, done, ready, result, exp);
    else pass++;
  endtask
  task automatic test_reset;
    reset = 1; valid = 0; flush = 0; op = 0; word = 0; a = 0; b = 0;
    step;
    step;
    total++;
    if (ready !== 1 || busy !== 0 || done !== 0 || result !== 64'd0)
      $display("FAIL reset state: ready=%b busy=%b done=%b result=%h want 1/0/0/0", ready, busy, done, result);
    else pass++;
    reset = 0;
    step;
    total++;
    if (ready !== 1 || done !== 0) $display("FAIL reset release: ready=%b done=%b want 1/0", ready, done); else pass++;
  endtask
  task automatic test_unsigned;
    run(2'b01, 0, 64'd100, 64'd7, 65, 64'd14, "divu_100_7");
    run(2'b11, 0, 64'd100, 64'd7, 65, 64'd2, "remu_100_7");
  endtask
  task automatic test_signed;
    run(2'b00, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
    run(2'b10, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, "rem_m7_2");
    run(2'b00, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFF2, "div_m100_7");
    run(2'b10, 0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 65, 64'd2, "rem_100_m7");
  endtask
  task automatic test_special;
    run(2'b01, 0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, "divu_by_zero");
    run(2'b11, 0, 64'd5, 64'd0, 1, 64'd5, "remu_by_zero");
    run(2'b00, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000, "div_ovf64");
  endtask
  task automatic test_word;
    run(2'b00, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000, "divw_ovf");
    run(2'b10, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 64'd0, "remw_ovf");
    run(2'b01, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFF, "divuw_ffff_1");
    run(2'b10, 1, 64'hDEAD_0000_0000_0011, 64'h1234_0000_0000_0005, 33, 64'd2, "remw_17_5");
  endtask
  task automatic test_flush;
    int bad = 0;
    op = 2'b01; word = 0; a = 64'd100; b = 64'd7; valid = 1;
    step;
    valid = 0;
    for (int i = 1; i < 10; i++) begin
      if (done !== 0 || busy !== 1) bad++;
      step;
    end
    flush = 1;
    #1;
    if (done !== 0) bad++;
    total++;
    if (bad != 0) $display("FAIL flush busy phase: %0d bad cycles want 0", bad); else pass++;
    step;
    flush = 0;
    total++;
    if (ready !== 1 || busy !== 0 || done !== 0) $display("FAIL flush idle: ready=%b busy=%b done=%b want 1/0/0", ready, busy, done); else pass++;
    run(2'b01, 0, 64'd9, 64'd3, 65, 64'd3, "divu_after_flush");
  endtask
  task automatic test_flush_valid_idle;
    op = 2'b01; word = 0; a = 64'd9; b = 64'd3; valid = 1; flush = 1;
    step;
    valid = 0; flush = 0;
    total++;
    if (ready !== 1 || busy !== 0) $display("FAIL flush_valid_idle: ready=%b busy=%b want 1/0", ready, busy); else pass++;
  endtask
  task automatic test_ignore_valid;
    op = 2'b01; word = 0; a = 64'd100; b = 64'd7; valid = 1;
    step;
    a = 64'd50; b = 64'd1;
    step;
    step;
    valid = 0;
    total++;
    if (busy !== 1) $display("FAIL ignore_valid busy: got %b want 1", busy); else pass++;
    for (int k = 3; k < 65 && done !== 1; k++) step;
    total++;
    if (done !== 1 || result !== 64'd14) $display("FAIL ignore_valid result: done=%b result=%h want 1/%h", done, result, 64'd14); else pass++;
    step;
  endtask
  task automatic test_reset_mid;
    int seen = 0;
    op = 2'b01; word = 0; a = 64'd100; b = 64'd7; valid = 1;
    step;
    valid = 0;
    for (int i = 0; i < 5; i++) step;
    reset = 1;
    step;
    reset = 0;
    total++;
    if (ready !== 1 || busy !== 0 || done !== 0 || result !== 64'd0)
      $display("FAIL reset_mid state: ready=%b busy=%b done=%b result=%h want 1/0/0/0", ready, busy, done, result);
    else pass++;
    for (int i = 0; i < 80; i++) begin
      if (done !== 0) seen++;
      step;
    end
    total++;
    if (seen != 0) $display("FAIL reset_mid done pulses: got %0d want 0", seen); else pass++;
    run(2'b11, 0, 64'd100, 64'd7, 65, 64'd2, "remu_after_reset");
  endtask
  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_special;
    test_word;
    test_flush_valid_idle;
    test_flush;
    test_ignore_valid;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port valid, input, 1 bit: the execute stage presents a divide/remainder request.
REQ-004 SHALL have port op, input, 2 bits: 00 div, 01 divu, 10 rem, 11 remu.
REQ-005 SHALL have port word, input, 1 bit: RV64 W-variant; operate on bits [31:0] only.
REQ-006 SHALL have port a, input, 64 bits: dividend (srca).
REQ-007 SHALL have port b, input, 64 bits: divisor (ope2).
REQ-008 SHALL have port flush, input, 1 bit: abort any request in flight.
REQ-009 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-010 SHALL have port busy, output, 1 bit: high in any state other than IDLE; the pipeline uses it to stall execute.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-012 SHALL have port result, output, 64 bits: quotient or remainder.

Function
REQ-013 SHALL implement states IDLE, BUSY and DONE; a request is accepted on a cycle where valid=1, ready=1 and flush=0.
REQ-014 SHALL latch op, word and operands on accept; later input changes SHALL NOT affect the operation.
REQ-015 SHALL use N=64 iterations, or N=32 when word=1, with a radix-2 restoring algorithm on operand magnitudes.
REQ-016 SHALL stay in BUSY for exactly N cycles, then enter DONE for one cycle; with accept in cycle t, done=1 in cycle t+N+1.
REQ-017 SHALL detect divide-by-zero and signed overflow on accept and go IDLE->DONE directly, with done=1 in cycle t+1.
REQ-018 SHALL, for divide-by-zero, return quotient all-ones and remainder equal to the dividend.
REQ-019 SHALL, for signed overflow (most negative / -1), return quotient equal to the dividend and remainder 0.
REQ-020 SHALL handle signs as follows: signed ops divide magnitudes; the quotient is negative iff operand signs differ; the remainder takes the dividend's sign.
REQ-021 SHALL, when word=1, sign- or zero-extend a[31:0] and b[31:0] per op, and sign-extend result[31:0] to 64 bits for all four ops, including the unsigned ones.
REQ-022 SHALL return DONE to IDLE unconditionally, so a new request can be accepted at t+N+2 at the earliest.
REQ-023 SHALL hold result stable from DONE until the next accept.
REQ-024 SHALL, when flush=1 in BUSY or DONE, go IDLE next cycle with done=0 for that and the following cycle; result is then don't-care.
REQ-025 SHALL, when flush=1 and valid=1 coincide in IDLE, not accept the request.
REQ-026 SHALL ignore valid while not in IDLE.

Reset
REQ-027 SHALL, while reset=1 on a clock edge, force state IDLE, iteration counter 0, result 0, done 0, busy 0 and ready 1.
REQ-028 SHALL give reset priority over flush and valid, and SHALL discard any operation in progress with no done pulse.

Verification
REQ-029 SHALL cover: divu a=100, b=7, word=0 -> done at t+65, result=14; same with remu -> result=2.
REQ-030 SHALL cover: div a=0xFFFF_FFFF_FFFF_FFF9 (-7), b=2 -> 0xFFFF_FFFF_FFFF_FFFD; rem -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-031 SHALL cover: divu a=5, b=0 -> done at t+1, result=0xFFFF_FFFF_FFFF_FFFF; remu a=5, b=0 -> result=5.
REQ-032 SHALL cover: div word=1, a=0x8000_0000, b=0xFFFF_FFFF -> done at t+1, result=0xFFFF_FFFF_8000_0000; rem word=1 -> result=0; divu word=1, a=0xFFFF_FFFF, b=1 -> done at t+33, result=0xFFFF_FFFF_FFFF_FFFF.
REQ-033 SHALL cover: flush asserted on the 10th BUSY cycle -> no done, ready=1 next cycle; an immediate divu a=9, b=3 then returns 3 at its t+65.
REQ-034 SHALL cover: reset asserted mid-BUSY -> the next cycle shows ready=1, busy=0, done=0, result=0, and no done pulse ever appears for the aborted request.
